// File: rtl/excode_conv_ctrl.sv
// Serialising controller for a bit-serial BCD-to-excess-3 converter: accepts a parallel
// BCD word, streams each digit LSB first, and collects the serial result and error flags.
module excode_conv_ctrl #(
  parameter int unsigned NDIG           = 4,
  parameter int unsigned CLR_EACH_DIGIT = 1
) (
  input  logic              CLK,
  input  logic              Clr,
  input  logic              InValid,
  output logic              InReady,
  input  logic [4*NDIG-1:0] InData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [4*NDIG-1:0] OutData,
  output logic [NDIG-1:0]   OutErrMask,
  output logic              OutErr,
  output logic              ConvX,
  output logic              ConvClrN,
  input  logic              ConvS,
  input  logic              ConvV,
  output logic              Busy
);

  localparam int unsigned DW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {StIdle, StClear, StShift, StDone} state_e;

  state_e              state, state_nxt;
  logic [DW-1:0]       dig, dig_nxt;
  logic [1:0]          bit_cnt, bit_nxt;
  logic [4*NDIG-1:0]   data;
  logic [4*NDIG-1:0]   shadow, shadow_nxt;
  logic [NDIG-1:0]     mask_shadow, mask_nxt;
  logic                transfer;

  assign InReady  = (state == StIdle) || ((state == StDone) && OutReady);
  assign transfer = InValid && InReady;
  assign OutErr   = |OutErrMask;

  always_comb begin
    state_nxt  = state;
    dig_nxt    = dig;
    bit_nxt    = bit_cnt;
    shadow_nxt = shadow;
    mask_nxt   = mask_shadow;
    unique case (state)
      StIdle: begin
        if (transfer) begin
          state_nxt = StClear;
          dig_nxt   = '0;
          bit_nxt   = '0;
        end
      end
      StClear: state_nxt = StShift;
      StShift: begin
        shadow_nxt[{dig, bit_cnt}] = ConvS;
        if (bit_cnt == 2'd3) begin
          mask_nxt[dig] = ConvV;
          if (dig == DW'(NDIG - 1)) begin
            state_nxt = StDone;
          end else begin
            dig_nxt   = dig + 1'b1;
            bit_nxt   = '0;
            state_nxt = (CLR_EACH_DIGIT != 0) ? StClear : StShift;
          end
        end else begin
          bit_nxt = bit_cnt + 1'b1;
        end
      end
      StDone: begin
        if (OutReady) begin
          // Back-to-back accept: the new word's first digit always gets a clear cycle.
          if (InValid) begin
            state_nxt = StClear;
            dig_nxt   = '0;
            bit_nxt   = '0;
          end else begin
            state_nxt = StIdle;
          end
        end
      end
      default: state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Clr) begin
      state      <= StIdle;
      dig        <= '0;
      bit_cnt    <= '0;
      OutValid   <= 1'b0;
      OutData    <= '0;
      OutErrMask <= '0;
      ConvX      <= 1'b0;
      ConvClrN   <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      state       <= state_nxt;
      dig         <= dig_nxt;
      bit_cnt     <= bit_nxt;
      shadow      <= shadow_nxt;
      mask_shadow <= mask_nxt;
      if (transfer) data <= InData;
      // Outputs are registered from the next state so they line up with the state they describe.
      ConvX    <= (state_nxt == StShift) && data[{dig_nxt, bit_nxt}];
      ConvClrN <= (state_nxt == StShift);
      OutValid <= (state_nxt == StDone);
      Busy     <= (state_nxt != StIdle);
      if ((state == StShift) && (state_nxt == StDone)) begin
        OutData    <= shadow_nxt;
        OutErrMask <= mask_nxt;
      end
    end
  end

endmodule

// File: tb/tb_excode_conv_ctrl.sv
// Bench for excode_conv_ctrl: two instances (per-digit clear and per-word clear), each paired
// with a behavioural serial excess-3 converter and a word-level timing/data model.
module tb_excode_conv_ctrl;

  logic        clk = 1'b0;
  logic [1:0]  clr, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [1:0]  conv_x, conv_clrn, conv_s, conv_v, busy;
  logic [15:0] in_data  [2];
  logic [15:0] out_data [2];
  logic [3:0]  out_mask [2];

  int n_chk  = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  excode_conv_ctrl #(.NDIG(4), .CLR_EACH_DIGIT(1)) u_dut0 (
    .CLK(clk), .Clr(clr[0]), .InValid(in_valid[0]), .InReady(in_ready[0]), .InData(in_data[0]),
    .OutValid(out_valid[0]), .OutReady(out_ready[0]), .OutData(out_data[0]),
    .OutErrMask(out_mask[0]), .OutErr(out_err[0]), .ConvX(conv_x[0]), .ConvClrN(conv_clrn[0]),
    .ConvS(conv_s[0]), .ConvV(conv_v[0]), .Busy(busy[0])
  );

  excode_conv_ctrl #(.NDIG(4), .CLR_EACH_DIGIT(0)) u_dut1 (
    .CLK(clk), .Clr(clr[1]), .InValid(in_valid[1]), .InReady(in_ready[1]), .InData(in_data[1]),
    .OutValid(out_valid[1]), .OutReady(out_ready[1]), .OutData(out_data[1]),
    .OutErrMask(out_mask[1]), .OutErr(out_err[1]), .ConvX(conv_x[1]), .ConvClrN(conv_clrn[1]),
    .ConvS(conv_s[1]), .ConvV(conv_v[1]), .Busy(busy[1])
  );

  // Serial converter: accumulates the digit bits seen so far and adds 3 to the partial value.
  logic [3:0] cv_acc [2];
  logic [1:0] cv_cnt [2];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      logic [3:0] cur;
      logic [4:0] ex;
      cur = cv_acc[i];
      cur[cv_cnt[i]] = conv_x[i];
      ex = {1'b0, cur} + 5'd3;
      conv_s[i] = ex[cv_cnt[i]];
      conv_v[i] = (cv_cnt[i] == 2'd3) && (cur > 4'd9);
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!conv_clrn[i]) begin
        cv_acc[i] <= 4'd0;
        cv_cnt[i] <= 2'd0;
      end else begin
        cv_acc[i] <= (cv_cnt[i] == 2'd3) ? 4'd0 : (cv_acc[i] | (4'(conv_x[i]) << cv_cnt[i]));
        cv_cnt[i] <= cv_cnt[i] + 2'd1;
      end
    end
  end

  function automatic logic [15:0] exp_data(input logic [15:0] d);
    logic [15:0] r;
    for (int k = 0; k < 4; k++) r[4*k +: 4] = d[4*k +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [3:0] exp_mask(input logic [15:0] d);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = (d[4*k +: 4] > 4'd9);
    return r;
  endfunction

  // Word-level model: handshake, fixed latency per instance, held output registers.
  logic [1:0]  m_busy  = 2'b00;
  logic [1:0]  m_valid = 2'b00;
  int          m_cnt   [2];
  logic [15:0] m_pend  [2];
  logic [15:0] m_out   [2];
  logic [3:0]  m_mask  [2];
  logic [3:0]  m_pmask [2];

  function automatic int lat(input int i);
    return (i == 0) ? 20 : 17;
  endfunction

  function automatic logic m_ready(input int i);
    return !m_busy[i] || (m_valid[i] && out_ready[i]);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (clr[i]) begin
        m_busy[i]  <= 1'b0;
        m_valid[i] <= 1'b0;
        m_out[i]   <= 16'h0;
        m_mask[i]  <= 4'h0;
      end else if (in_valid[i] && m_ready(i)) begin
        m_busy[i]  <= 1'b1;
        m_valid[i] <= 1'b0;
        m_cnt[i]   <= lat(i) - 1;
        m_pend[i]  <= exp_data(in_data[i]);
        m_pmask[i] <= exp_mask(in_data[i]);
      end else if (m_valid[i] && out_ready[i]) begin
        m_valid[i] <= 1'b0;
        m_busy[i]  <= 1'b0;
      end else if (m_busy[i] && !m_valid[i]) begin
        if (m_cnt[i] == 0) begin
          m_valid[i] <= 1'b1;
          m_out[i]   <= m_pend[i];
          m_mask[i]  <= m_pmask[i];
        end else begin
          m_cnt[i] <= m_cnt[i] - 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("model OutValid[%0d]", i), 32'(out_valid[i]), 32'(m_valid[i]));
        chk($sformatf("model InReady[%0d]", i), 32'(in_ready[i]), 32'(m_ready(i)));
        chk($sformatf("model Busy[%0d]", i), 32'(busy[i]), 32'(m_busy[i]));
        chk($sformatf("model OutData[%0d]", i), 32'(out_data[i]), 32'(m_out[i]));
        chk($sformatf("model OutErrMask[%0d]", i), 32'(out_mask[i]), 32'(m_mask[i]));
        chk($sformatf("model OutErr[%0d]", i), 32'(out_err[i]), 32'(|m_mask[i]));
      end
    end
  end

  task automatic send(input int i, input logic [15:0] d);
    in_data[i]  = d;
    in_valid[i] = 1'b1;
    @(posedge clk);
    #1 in_valid[i] = 1'b0;
  endtask

  // Counts edges until OutValid, plus cycles with ConvClrN low along the way.
  task automatic wait_valid(input int i, output int n, output int nclr);
    n = 0;
    nclr = 0;
    while (!out_valid[i] && n < 100) begin
      if (!conv_clrn[i]) nclr++;
      @(posedge clk);
      #1 n++;
    end
    if (n >= 100) chk("wait OutValid timeout", 32'(n), 32'd0);
  endtask

  task automatic release_word(input int i);
    out_ready[i] = 1'b1;
    @(posedge clk);
    #1 out_ready[i] = 1'b0;
  endtask

  initial begin
    int n, nclr;
    logic [3:0]  pat;
    logic [15:0] held;
    clr = 2'b11;
    in_valid = 2'b00;
    out_ready = 2'b00;
    in_data[0] = 16'h0;
    in_data[1] = 16'h0;
    repeat (3) @(posedge clk);
    #1 clr = 2'b00;
    chk_en = 1'b1;

    for (int i = 0; i < 2; i++) begin
      chk("reset OutValid", 32'(out_valid[i]), 32'd0);
      chk("reset OutData", 32'(out_data[i]), 32'd0);
      chk("reset OutErrMask", 32'(out_mask[i]), 32'd0);
      chk("reset ConvX", 32'(conv_x[i]), 32'd0);
      chk("reset ConvClrN", 32'(conv_clrn[i]), 32'd0);
      chk("reset Busy", 32'(busy[i]), 32'd0);
      chk("reset InReady", 32'(in_ready[i]), 32'd1);
    end

    // Basic word and latency.
    send(0, 16'h1234);
    in_data[0] = 16'hFFFF;
    wait_valid(0, n, nclr);
    chk("1234 latency", 32'(n), 32'd20);
    chk("1234 OutData", 32'(out_data[0]), 32'h4567);
    chk("1234 OutErrMask", 32'(out_mask[0]), 32'h0);
    chk("1234 clear cycles", 32'(nclr), 32'd4);
    release_word(0);

    // Serial pattern of digit 0 = 9.
    send(0, 16'h0009);
    chk("d9 clear ConvClrN", 32'(conv_clrn[0]), 32'd0);
    chk("d9 clear ConvX", 32'(conv_x[0]), 32'd0);
    pat = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("d9 bit%0d ConvClrN", k), 32'(conv_clrn[0]), 32'd1);
      chk($sformatf("d9 bit%0d ConvX", k), 32'(conv_x[0]), 32'(pat[k]));
    end
    @(posedge clk);
    #1 chk("d9 next clear ConvClrN", 32'(conv_clrn[0]), 32'd0);
    wait_valid(0, n, nclr);
    chk("0009 OutData", 32'(out_data[0]), 32'h3333 + 32'h9);
    release_word(0);

    // Invalid digit, held output, back-to-back accept.
    send(0, 16'h9A05);
    wait_valid(0, n, nclr);
    chk("9A05 OutErrMask", 32'(out_mask[0]), 32'b0100);
    chk("9A05 OutErr", 32'(out_err[0]), 32'd1);
    chk("9A05 digits 0,1,3", 32'(out_data[0] & 16'hF0FF), 32'hC038);
    held = out_data[0];
    in_data[0] = 16'h0000;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("hold OutData", 32'(out_data[0] & 16'hF0FF), 32'hC038);
      chk("hold InReady", 32'(in_ready[0]), 32'd0);
      chk("hold OutValid", 32'(out_valid[0]), 32'd1);
    end
    chk("hold full word", 32'(out_data[0]), 32'(held));
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    @(posedge clk);
    #1 out_ready[0] = 1'b0;
    in_valid[0] = 1'b0;
    chk("b2b OutValid", 32'(out_valid[0]), 32'd0);
    chk("b2b Busy", 32'(busy[0]), 32'd1);
    wait_valid(0, n, nclr);
    chk("b2b latency", 32'(n), 32'd20);
    chk("b2b OutData", 32'(out_data[0]), 32'h3333);
    release_word(0);

    // Abort during the second digit.
    send(0, 16'h5678);
    repeat (7) @(posedge clk);
    #1 clr[0] = 1'b1;
    @(posedge clk);
    #1 clr[0] = 1'b0;
    chk("abort Busy", 32'(busy[0]), 32'd0);
    chk("abort ConvClrN", 32'(conv_clrn[0]), 32'd0);
    chk("abort OutValid", 32'(out_valid[0]), 32'd0);
    chk("abort InReady", 32'(in_ready[0]), 32'd1);
    n = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1 if (out_valid[0]) n++;
    end
    chk("abort no OutValid", 32'(n), 32'd0);
    send(0, 16'h0000);
    wait_valid(0, n, nclr);
    chk("after abort OutData", 32'(out_data[0]), 32'h3333);
    release_word(0);

    // One clear cycle per word.
    send(1, 16'h0987);
    wait_valid(1, n, nclr);
    chk("word-clear latency", 32'(n), 32'd17);
    chk("word-clear OutData", 32'(out_data[1]), 32'h3CBA);
    chk("word-clear clear cycles", 32'(nclr), 32'd1);
    chk("word-clear OutErr", 32'(out_err[1]), 32'd0);
    release_word(1);

    repeat (3) @(posedge clk);
    #1 chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
